// File: rtl/simple_log_pkg.sv
// Shared constants and helpers for the simple logging facility (writer and reader sides).
package simple_log_pkg;

    localparam int LOG_ENTRY_W = 64;
    localparam int DROP_CNT_W  = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        RESP_SEL_NONE   = 2'd0,
        RESP_SEL_ENTRY  = 2'd1,
        RESP_SEL_STATUS = 2'd2
    } resp_sel_e;

    function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] cnt);
        logic [DROP_CNT_W-1:0] nxt;
        if (cnt == DROP_CNT_MAX) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 16'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/simple_log_ram.sv
// 1R1W log storage: registered read-first output, no reset so it maps onto block RAM.
module simple_log_ram
    import simple_log_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = LOG_ENTRY_W
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Write port and read-first registered read port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/simple_log_writer.sv
// Capture side of the log: circular write pointer, wrap flag, drop counter and read port.
// Optional SIMPLE_LOG_STOP_ON_WRAP_EN halts capture after the first full buffer.
module simple_log_writer
    import simple_log_pkg::*;
#(
    parameter int ADDR_W             = 8,
    parameter int RESP_DATA_STRUCT_W = LOG_ENTRY_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          log_wr_val,
    input  logic [RESP_DATA_STRUCT_W-1:0] log_wr_data,
    output logic                          log_wr_rdy,
    input  logic                          log_en,
    input  logic                          log_clear,
    input  logic                          log_rd_req_val,
    input  logic [ADDR_W-1:0]             log_rd_req_addr,
    output logic                          log_rd_resp_val,
    output logic [RESP_DATA_STRUCT_W-1:0] log_rd_resp_data,
    output logic [ADDR_W-1:0]             curr_wr_addr,
    output logic                          has_wrapped,
    output logic [DROP_CNT_W-1:0]         dropped_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0]     r_wr_addr;
    logic                  r_has_wrapped;
    logic [DROP_CNT_W-1:0] r_dropped_cnt;
    logic                  r_resp_val;
    logic                  w_halted;
    logic                  w_wr_fire;
    logic                  w_drop;
    logic                  w_wrap_write;

`ifdef SIMPLE_LOG_STOP_ON_WRAP_EN
    logic r_halted;

    // Halt latches on the wrapping write; only clear or reset releases it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (log_clear) begin
            r_halted <= 1'b0;
        end else if (w_wrap_write) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    assign log_wr_rdy   = ~w_halted;
    // A clear in the same cycle swallows the offered entry without counting it
    assign w_wr_fire    = log_wr_val & ~w_halted & log_en & ~log_clear;
    assign w_drop       = log_wr_val & ~log_clear & (~log_en | w_halted);
    assign w_wrap_write = w_wr_fire & (r_wr_addr == LAST_ADDR);

    // Write pointer, sticky wrap flag and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr     <= {ADDR_W{1'b0}};
            r_has_wrapped <= 1'b0;
            r_dropped_cnt <= {DROP_CNT_W{1'b0}};
        end else if (log_clear) begin
            r_wr_addr     <= {ADDR_W{1'b0}};
            r_has_wrapped <= 1'b0;
            r_dropped_cnt <= {DROP_CNT_W{1'b0}};
        end else begin
            if (w_wr_fire) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (w_wrap_write) begin
                r_has_wrapped <= 1'b1;
            end
            if (w_drop) begin
                r_dropped_cnt <= drop_cnt_inc(r_dropped_cnt);
            end
        end
    end

    // One-deep response-valid pipe aligned with the RAM read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_val <= 1'b0;
        end else begin
            r_resp_val <= log_rd_req_val;
        end
    end

    simple_log_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RESP_DATA_STRUCT_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (log_wr_data),
        .i_rd_en   (log_rd_req_val),
        .i_rd_addr (log_rd_req_addr),
        .o_rd_data (log_rd_resp_data)
    );

    assign curr_wr_addr    = r_wr_addr;
    assign has_wrapped     = r_has_wrapped;
    assign dropped_cnt     = r_dropped_cnt;
    assign log_rd_resp_val = r_resp_val;

endmodule

// File: tb/tb_simple_log_writer.sv
// Scoreboard bench for simple_log_writer (ADDR_W=4): directed scenarios plus random traffic.
module tb_simple_log_writer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          log_wr_val = 1'b0;
    logic [DW-1:0] log_wr_data = '0;
    logic          log_wr_rdy;
    logic          log_en = 1'b0;
    logic          log_clear = 1'b0;
    logic          log_rd_req_val = 1'b0;
    logic [AW-1:0] log_rd_req_addr = '0;
    logic          log_rd_resp_val;
    logic [DW-1:0] log_rd_resp_data;
    logic [AW-1:0] curr_wr_addr;
    logic          has_wrapped;
    logic [15:0]   dropped_cnt;

    simple_log_writer #(.ADDR_W(AW), .RESP_DATA_STRUCT_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .log_wr_val       (log_wr_val),
        .log_wr_data      (log_wr_data),
        .log_wr_rdy       (log_wr_rdy),
        .log_en           (log_en),
        .log_clear        (log_clear),
        .log_rd_req_val   (log_rd_req_val),
        .log_rd_req_addr  (log_rd_req_addr),
        .log_rd_resp_val  (log_rd_resp_val),
        .log_rd_resp_data (log_rd_resp_data),
        .curr_wr_addr     (curr_wr_addr),
        .has_wrapped      (has_wrapped),
        .dropped_cnt      (dropped_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            chk;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    int            m_ptr = 0;
    bit            m_wrapped = 1'b0;
    int            m_drop = 0;
    bit            m_halt = 1'b0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model applies the logging rules at the edge
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit en, input bit clr,
                        input bit rv, input int ra);
        exp_t e;
        log_wr_val      = wv;
        log_wr_data     = wd;
        log_en          = en;
        log_clear       = clr;
        log_rd_req_val  = rv;
        log_rd_req_addr = ra[AW-1:0];
        if (rv) begin
            e.data = m_valid[ra] ? m_mem[ra] : '0;
            e.cyc  = cyc + 1;
            e.chk  = m_valid[ra];
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (clr) begin
            m_ptr = 0; m_wrapped = 1'b0; m_drop = 0; m_halt = 1'b0;
        end else if (wv) begin
            if (!en || m_halt) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_mem[m_ptr]   = wd;
                m_valid[m_ptr] = 1'b1;
                m_ptr = (m_ptr + 1) % DEPTH;
                if (m_ptr == 0) begin
                    m_wrapped = 1'b1;
`ifdef SIMPLE_LOG_STOP_ON_WRAP_EN
                    m_halt = 1'b1;
`endif
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b1, d, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic rd(input int a);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
    endtask

    // Monitor: pops the scoreboard on every response and tracks status outputs
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                chk("resp_missing", {63'd0, log_rd_resp_val}, 64'd1);
            end
            if (log_rd_resp_val) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_latency", 64'(cyc), 64'(e.cyc));
                    if (e.chk) chk("resp_data", log_rd_resp_data, e.data);
                end
            end
            chk("curr_wr_addr", 64'(curr_wr_addr), 64'(m_ptr % DEPTH));
            chk("has_wrapped", 64'(has_wrapped), 64'(m_wrapped));
            chk("dropped_cnt", 64'(dropped_cnt), 64'(m_drop));
            chk("log_wr_rdy", 64'(log_wr_rdy), 64'(!m_halt));
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_val", 64'(log_rd_resp_val), 64'd0);
        chk("reset_rdy", 64'(log_wr_rdy), 64'd1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("reset_addr", 64'(curr_wr_addr), 64'd0);
        chk("reset_wrapped", 64'(has_wrapped), 64'd0);
        chk("reset_dropped", 64'(dropped_cnt), 64'd0);

        // Five entries, then read them back
        for (int i = 0; i < 5; i++) wr(64'hA0 + 64'(i));
        chk("five_addr", 64'(curr_wr_addr), 64'd5);
        chk("five_wrapped", 64'(has_wrapped), 64'd0);
        for (int i = 0; i < 5; i++) rd(i);
        idle(2);

        // Fill past one full buffer
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) wr(64'hD0 + 64'(i));
        chk("wrap_addr", 64'(curr_wr_addr), 64'd0);
        chk("wrap_flag", 64'(has_wrapped), 64'd1);
        wr(64'hD0 + 64'd16);
`ifdef SIMPLE_LOG_STOP_ON_WRAP_EN
        chk("halt_addr", 64'(curr_wr_addr), 64'd0);
        chk("halt_rdy", 64'(log_wr_rdy), 64'd0);
        chk("halt_dropped", 64'(dropped_cnt), 64'd1);
`else
        chk("overwrite_addr", 64'(curr_wr_addr), 64'd1);
`endif
        rd(0);
        rd(1);
        idle(2);

        // Read/write collision at address 3
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) wr(64'hF0 + 64'(i));
        wr(64'h11);
        for (int i = 0; i < 12; i++) wr(64'hE0 + 64'(i));
        for (int i = 0; i < 3; i++) wr(64'hC0 + 64'(i));
        step(1'b1, 64'h22, 1'b1, 1'b0, 1'b1, 3);
        rd(3);
        idle(2);

        // Disabled logging drops entries; clear swallows a coincident write
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 0);
        wr(64'h51);
        wr(64'h52);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h99, 1'b0, 1'b0, 1'b0, 0);
        chk("dis_addr", 64'(curr_wr_addr), 64'd2);
        chk("dis_dropped", 64'(dropped_cnt), 64'd3);
        step(1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 0);
        chk("clr_addr", 64'(curr_wr_addr), 64'd0);
        chk("clr_dropped", 64'(dropped_cnt), 64'd0);
        rd(0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 2), {$urandom, $urandom}, ($urandom % 4) != 0,
                 ($urandom % 40) == 0, 1'($urandom % 2), int'($urandom % DEPTH));
        end
        idle(2);

        // Asynchronous reset between a request and its response
        wr(64'h1234);
        rd(0);
        rst_n = 1'b0;
        #1;
        chk("arst_resp_val", 64'(log_rd_resp_val), 64'd0);
        chk("arst_addr", 64'(curr_wr_addr), 64'd0);
        chk("arst_wrapped", 64'(has_wrapped), 64'd0);
        chk("arst_dropped", 64'(dropped_cnt), 64'd0);
        chk("arst_rdy", 64'(log_wr_rdy), 64'd1);
        sb_q.delete();
        m_ptr = 0; m_wrapped = 1'b0; m_drop = 0; m_halt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(64'hBEEF);
        chk("post_rst_addr", 64'(curr_wr_addr), 64'd1);
        rd(0);
        idle(3);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
